// File: rtl/score_keeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : score_pkg
//  Brief    : Shared constants, widths and lane-state encoding for the
//             score_keeper block and its lane_judge sub-module.
//  Revision : 1.0 - initial release
// ============================================================================
package score_pkg;

   localparam int NUM_LANES = 5;
   localparam int SCORE_MAX = 99999;
   localparam int SCORE_W   = 17;
   localparam int COMBO_W   = 8;

   // Per-lane judging state; 2-bit encoding with explicit values
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LIVE  = 2'd1,
      SPENT = 2'd2
   } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/score_keeper_lane_judge.sv
`default_nettype none
// ============================================================================
//  Module   : lane_judge
//  Brief    : One lane of the note judge: button press detection, the
//             EMPTY/LIVE/SPENT judging FSM, registered hit/miss/ghost pulses
//             and the per-lane hit-flash frame counter.
//  Revision : 1.0 - initial release
// ============================================================================
module lane_judge
   import score_pkg::*;
#(
   parameter int FLASH_FRAMES = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_tick,
   input  logic btn,
   input  logic note_in_zone,
   output logic hit,
   output logic miss,
   output logic ghost,
   output logic flash
);

   localparam int CNT_W = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

   logic             r_btn_q;
   logic             w_press;
   lane_state_t      r_state;
   lane_state_t      w_next_state;
   logic             w_hit;
   logic             w_miss;
   logic             w_ghost;
   logic             r_hit;
   logic             r_miss;
   logic             r_ghost;
   logic [CNT_W-1:0] r_flash_cnt;

   // Previous button level; reset to 1 so a button held through reset is not a press
   always_ff @(posedge clk) begin
      if (reset) r_btn_q <= 1'b1;
      else       r_btn_q <= btn;
   end

   assign w_press = btn & ~r_btn_q;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= EMPTY;
      else       r_state <= w_next_state;
   end

   // FSM next state: a press while judgeable always wins over the zone falling
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         EMPTY: begin
            if (note_in_zone) w_next_state = w_press ? SPENT : LIVE;
         end
         LIVE: begin
            if (w_press)            w_next_state = SPENT;
            else if (!note_in_zone) w_next_state = EMPTY;
         end
         SPENT: begin
            if (!note_in_zone) w_next_state = EMPTY;
         end
         default: w_next_state = EMPTY;
      endcase
   end

   // FSM outputs: judgement events for the current cycle
   always_comb begin
      w_hit   = 1'b0;
      w_miss  = 1'b0;
      w_ghost = 1'b0;
      case (r_state)
         EMPTY: begin
            w_hit   = note_in_zone & w_press;
            w_ghost = ~note_in_zone & w_press;
         end
         LIVE: begin
            w_hit  = w_press;
            w_miss = ~w_press & ~note_in_zone;
         end
         default: ;
      endcase
   end

   // One-cycle judgement pulses, presented the cycle after the event
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit   <= 1'b0;
         r_miss  <= 1'b0;
         r_ghost <= 1'b0;
      end else begin
         r_hit   <= w_hit;
         r_miss  <= w_miss;
         r_ghost <= w_ghost;
      end
   end

   // Flash counter: a hit reloads it (beating a coincident frame decrement)
   always_ff @(posedge clk) begin
      if (reset)
         r_flash_cnt <= '0;
      else if (r_hit)
         r_flash_cnt <= CNT_W'(FLASH_FRAMES);
      else if (frame_tick && (r_flash_cnt != '0))
         r_flash_cnt <= r_flash_cnt - 1'b1;
   end

   assign hit   = r_hit;
   assign miss  = r_miss;
   assign ghost = r_ghost;
   assign flash = (r_flash_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Brief    : Judges button presses against notes in the hit zone on every
//             lane, accumulates a saturating 0..99999 score, a combo count
//             and a derived score multiplier, and drives hit-flash flags.
//  Options  : GHOST_PENALTY_EN - when defined, a ghost press (button press
//             with no note in the zone) clears the combo like a miss.
//  Revision : 1.0 - initial release
// ============================================================================
module score_keeper
   import score_pkg::*;
#(
   parameter int NUM_LANES      = 5,
   parameter int POINTS_PER_HIT = 10,
   parameter int COMBO_STEP     = 10,
   parameter int MULT_MAX       = 4,
   parameter int FLASH_FRAMES   = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_tick,
   input  logic [NUM_LANES-1:0] btn,
   input  logic [NUM_LANES-1:0] note_in_zone,
   output logic [SCORE_W-1:0]   score,
   output logic [COMBO_W-1:0]   combo,
   output logic [2:0]           multiplier,
   output logic [NUM_LANES-1:0] hit_flash
);

   localparam int N_W   = $clog2(NUM_LANES + 1);
   localparam int ADD_W = 18;

   logic [NUM_LANES-1:0] w_hit;
   logic [NUM_LANES-1:0] w_miss;
   logic [NUM_LANES-1:0] w_ghost;
   logic [NUM_LANES-1:0] w_flash;
   logic [N_W-1:0]       w_n;
   logic [COMBO_W-1:0]   w_steps;
   logic [ADD_W-1:0]     w_add;
   logic [ADD_W-1:0]     w_sum;
   logic [SCORE_W-1:0]   w_score_next;
   logic [COMBO_W:0]     w_combo_sum;
   logic [COMBO_W-1:0]   w_combo_next;
   logic                 w_clear;
   logic [SCORE_W-1:0]   r_score;
   logic [COMBO_W-1:0]   r_combo;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_judge #(
         .FLASH_FRAMES (FLASH_FRAMES)
      ) u_lane_judge (
         .clk          (clk),
         .reset        (reset),
         .frame_tick   (frame_tick),
         .btn          (btn[i]),
         .note_in_zone (note_in_zone[i]),
         .hit          (w_hit[i]),
         .miss         (w_miss[i]),
         .ghost        (w_ghost[i]),
         .flash        (w_flash[i])
      );
   end

   // Number of lanes hit this cycle
   always_comb begin
      w_n = '0;
      for (int i = 0; i < NUM_LANES; i++)
         w_n = w_n + N_W'(w_hit[i]);
   end

   // Multiplier follows the combo register directly, so hits score at the pre-update value
   always_comb begin
      w_steps = r_combo / COMBO_W'(COMBO_STEP);
      if (w_steps >= COMBO_W'(MULT_MAX - 1))
         multiplier = 3'(MULT_MAX);
      else
         multiplier = 3'(w_steps) + 3'd1;
   end

`ifdef GHOST_PENALTY_EN
   // Combo break condition: any miss or any ghost press
   always_comb begin
      w_clear = (|w_miss) | (|w_ghost);
   end
`else
   logic w_ghost_unused;
   assign w_ghost_unused = |w_ghost;

   // Combo break condition: any miss; ghost presses carry no penalty
   always_comb begin
      w_clear = |w_miss;
   end
`endif

   // Next score and combo, both saturating; misses zero the combo but hits still score
   always_comb begin
      w_add       = ADD_W'(POINTS_PER_HIT) * ADD_W'(multiplier) * ADD_W'(w_n);
      w_sum       = ADD_W'(r_score) + w_add;
      w_combo_sum = {1'b0, r_combo} + (COMBO_W + 1)'(w_n);
      if (w_sum > ADD_W'(SCORE_MAX))
         w_score_next = SCORE_W'(SCORE_MAX);
      else
         w_score_next = w_sum[SCORE_W-1:0];
      if (w_clear)
         w_combo_next = '0;
      else if (w_combo_sum[COMBO_W])
         w_combo_next = {COMBO_W{1'b1}};
      else
         w_combo_next = w_combo_sum[COMBO_W-1:0];
   end

   // Score and combo registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_score <= '0;
         r_combo <= '0;
      end else begin
         r_score <= w_score_next;
         r_combo <= w_combo_next;
      end
   end

   assign score     = r_score;
   assign combo     = r_combo;
   assign hit_flash = w_flash;

endmodule
`default_nettype wire
